// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Runs the host request sequence (clock inhibit, start bit, 8 data bits LSB
// first, odd parity, stop bit, device ack) on open-drain clock/data enables.
// The enables are wired-ANDed with the device side at the top level.
module ps2_host_tx #(
  parameter int unsigned INHIBIT = 3547,   // request-phase clock hold, cycles
  parameter int unsigned TIMEOUT = 532020  // clock release to end of ack, cycles
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2CkIn,
  input  logic       ps2DqIn,
  output logic       ps2CkOe,
  output logic       ps2DqOe,
  input  logic [7:0] data,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned IW = (INHIBIT > 1) ? $clog2(INHIBIT) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_ACKW,
    S_FIN
  } state_e;

  // Pin conditioning
  logic [1:0] ck_sync_q;
  logic [1:0] dq_sync_q;
  logic       ck_prev_q;
  logic       ck;
  logic       dq;
  logic       fall;

  // Control and datapath state
  state_e          state_q,  state_d;
  logic [7:0]      shreg_q,  shreg_d;
  logic            par_q,    par_d;
  logic [3:0]      n_q,      n_d;
  logic [IW-1:0]   inh_q,    inh_d;
  logic [TW-1:0]   tmo_q,    tmo_d;
  logic            ck_oe_q,  ck_oe_d;
  logic            dq_oe_q,  dq_oe_d;
  logic            busy_q,   busy_d;
  logic            done_q,   done_d;
  logic            err_q,    err_d;
  logic            dq_send;

  assign ck   = ck_sync_q[1];
  assign dq   = dq_sync_q[1];
  assign fall = ck_prev_q & ~ck;

  // Two-flop synchronizers on both pins plus the previous clock level.
  // Idle PS/2 lines float high, so the chain resets to 1.
  always_ff @(posedge clock) begin
    // NOTE: clocked state is assigned with <= so every flop samples the
    // pre-edge values; blocking = here would chain the sync stages into one.
    if (reset) begin
      ck_sync_q <= 2'b11;
      dq_sync_q <= 2'b11;
      ck_prev_q <= 1'b1;
    end else begin
      ck_sync_q <= {ck_sync_q[0], ps2CkIn};
      dq_sync_q <= {dq_sync_q[0], ps2DqIn};
      ck_prev_q <= ck;
    end
  end

  // Next-state, datapath and registered-output decode.
  always_comb begin
    // NOTE: every signal written below gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    state_d = state_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    n_d     = n_q;
    inh_d   = inh_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    dq_send = dq_oe_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          shreg_d = data;
          par_d   = ~^data;
          err_d   = 1'b0;
          inh_d   = '0;
          state_d = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        if (inh_q == INH_LAST) begin
          state_d = S_REQ;
        end else begin
          inh_d = inh_q + 1'b1;
        end
      end

      S_REQ: begin
        tmo_d   = '0;
        n_d     = '0;
        state_d = S_SEND;
      end

      S_SEND: begin
        tmo_d = tmo_q + 1'b1;
        // Timeout wins over a clock edge arriving in the same cycle.
        if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else if (fall) begin
          n_d = n_q + 1'b1;
          if (n_q < 4'd8) begin
            dq_send = ~shreg_q[0];
            shreg_d = shreg_q >> 1;
          end else if (n_q == 4'd8) begin
            dq_send = ~par_q;
          end else if (n_q == 4'd9) begin
            dq_send = 1'b0;
          end else begin
            // Eleventh edge: device must hold data low as its ack.
            err_d   = dq;
            state_d = S_ACKW;
          end
        end
      end

      S_ACKW: begin
        tmo_d = tmo_q + 1'b1;
        if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else if (ck && dq) begin
          state_d = S_FIN;
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs follow the state being entered so they are all registered.
    ck_oe_d = (state_d == S_INHIBIT) || (state_d == S_REQ);
    dq_oe_d = (state_d == S_REQ) ? 1'b1 :
              (state_d == S_SEND) ? dq_send : 1'b0;
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_FIN);
  end

  // State, counters and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      par_q   <= 1'b0;
      n_q     <= '0;
      inh_q   <= '0;
      tmo_q   <= '0;
      ck_oe_q <= 1'b0;
      dq_oe_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      n_q     <= n_d;
      inh_q   <= inh_d;
      tmo_q   <= tmo_d;
      ck_oe_q <= ck_oe_d;
      dq_oe_q <= dq_oe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign ps2CkOe = ck_oe_q;
  assign ps2DqOe = dq_oe_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign error   = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized scoreboard bench for ps2_host_tx with a
// behavioural PS/2 device on a wired-AND bus.
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int TMO  = 2000;
  localparam int HALF = 40;
  localparam int IDLE_BOUND = INH + TMO + 200;

  localparam int M_ACK    = 0;
  localparam int M_NACK   = 1;
  localparam int M_SILENT = 2;

  typedef struct {
    logic [7:0] data;
    int         mode;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] data  = 8'h00;
  logic       ps2CkOe, ps2DqOe, busy, done, error;

  logic dev_ck = 1'b1;
  logic dev_dq = 1'b1;
  wire  pin_ck = dev_ck & ~ps2CkOe;
  wire  pin_dq = dev_dq & ~ps2DqOe;

  int         n_checks = 0;
  int         n_pass   = 0;
  exp_t       exp_q[$];
  int         dev_mode  = M_ACK;
  bit         dev_abort = 1'b0;
  bit         dev_active = 1'b0;
  int         fall_cnt = 0;
  int         rx_cnt   = 0;
  logic [9:0] rx_bits  = '0;

  ps2_host_tx #(.INHIBIT(INH), .TIMEOUT(TMO)) dut (
    .clock   (clock),
    .reset   (reset),
    .ps2CkIn (pin_ck),
    .ps2DqIn (pin_dq),
    .ps2CkOe (ps2CkOe),
    .ps2DqOe (ps2DqOe),
    .data    (data),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .error   (error)
  );

  always #5 clock = ~clock;

  initial begin
    #800000;
    $display("FAIL watchdog: got still running, required finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  // Expected 10-bit line frame: data LSB first, odd parity, stop.
  function automatic logic [9:0] frame_of(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {1'b1, (ones % 2 == 0), d};
  endfunction

  task automatic wait_half();
    repeat (HALF) @(negedge clock);
  endtask

  // Device: on seeing clock released with data held low, clock 11 pulses,
  // read each host bit while the clock is low, and optionally ack.
  initial begin : device
    forever begin
      @(negedge clock);
      if (pin_ck && !pin_dq && dev_mode != M_SILENT && !reset && !dev_abort) begin
        dev_active = 1'b1;
        rx_cnt     = 0;
        fall_cnt   = 0;
        rx_bits    = '0;
        wait_half();
        for (int i = 0; i < 11 && !dev_abort; i++) begin
          if (i == 10 && dev_mode == M_ACK) dev_dq = 1'b0;
          dev_ck = 1'b0;
          fall_cnt++;
          wait_half();
          if (i < 10 && !dev_abort) begin
            rx_bits[i] = pin_dq;
            rx_cnt++;
          end
          dev_ck = 1'b1;
          dev_dq = 1'b1;
          wait_half();
        end
        dev_ck = 1'b1;
        dev_dq = 1'b1;
        dev_active = 1'b0;
      end
    end
  end

  // Scoreboard monitor: every done pulse retires one expected transfer.
  initial begin : monitor
    exp_t       e;
    logic [9:0] f;
    forever begin
      @(negedge clock);
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_done: got done=1, required no pending transfer");
        end else begin
          e = exp_q.pop_front();
          check("done_error", error, (e.mode != M_ACK));
          check("done_lines_released", {ps2CkOe, ps2DqOe}, 0);
          check("done_busy", busy, 1);
          if (e.mode != M_SILENT) begin
            f = frame_of(e.data);
            check("rx_bit_count", rx_cnt, 10);
            check("rx_data", rx_bits[7:0], f[7:0]);
            check("rx_parity", rx_bits[8], f[8]);
            check("rx_stop", rx_bits[9], f[9]);
          end
          @(negedge clock);
          check("busy_after_done", busy, 0);
          check("done_one_cycle", done, 0);
          check("error_holds", error, (e.mode != M_ACK));
          check("lines_idle_after", {ps2CkOe, ps2DqOe}, 0);
        end
      end
    end
  end

  task automatic wait_idle();
    int c = 0;
    while (busy !== 1'b0 && c < IDLE_BOUND) begin
      @(negedge clock);
      c++;
    end
    check("idle_within_bound", busy, 0);
  endtask

  task automatic issue(input logic [7:0] d, input int mode);
    exp_t e;
    dev_mode = mode;
    fall_cnt = 0;
    data     = d;
    start    = 1'b1;
    e.data   = d;
    e.mode   = mode;
    exp_q.push_back(e);
    @(negedge clock);
    start = 1'b0;
    data  = 8'($urandom);
    check("accept_busy", busy, 1);
    check("accept_ck_inhibit", ps2CkOe, 1);
  endtask

  // Starts on the first cycle after acceptance; returns at SEND entry.
  task automatic measure_request();
    int idx    = 0;
    int dq_idx = -1;
    while (ps2CkOe === 1'b1 && idx < 4 * INH) begin
      if (ps2DqOe === 1'b1 && dq_idx < 0) dq_idx = idx;
      @(negedge clock);
      idx++;
    end
    check("ck_inhibit_len", idx, INH + 1);
    check("dq_start_bit_cycle", dq_idx, INH);
    check("start_bit_held", ps2DqOe, 1);
  endtask

  task automatic xfer(input logic [7:0] d, input int mode);
    issue(d, mode);
    measure_request();
    wait_idle();
  endtask

  initial begin : stimulus
    int c;
    int seen;

    repeat (3) @(negedge clock);
    check("reset_ck_oe", ps2CkOe, 0);
    check("reset_dq_oe", ps2DqOe, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_error", error, 0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // Directed bytes, including both parity polarities.
    xfer(8'hED, M_ACK);
    xfer(8'h07, M_ACK);
    xfer(8'h00, M_ACK);

    // Device leaves data high on the ack edge.
    xfer(8'h96, M_NACK);

    // Device never clocks: done exactly TMO cycles after SEND entry.
    issue(8'hA5, M_SILENT);
    measure_request();
    c = 0;
    while (done !== 1'b1 && c < TMO + 50) begin
      @(negedge clock);
      c++;
    end
    check("timeout_cycles", c, TMO);
    check("timeout_error", error, 1);
    wait_idle();

    // A start during SEND is neither taken nor queued.
    issue(8'h3C, M_ACK);
    measure_request();
    c = 0;
    while (fall_cnt < 2 && c < 10 * HALF) begin
      @(negedge clock);
      c++;
    end
    data  = 8'hC3;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("busy_during_send", busy, 1);
    wait_idle();
    repeat (5) @(negedge clock);
    check("no_queued_start", busy, 0);
    check("no_queued_inhibit", ps2CkOe, 0);

    // Reset after the 4th falling edge.
    issue(8'h5A, M_ACK);
    measure_request();
    c = 0;
    while (fall_cnt < 4 && c < 12 * HALF) begin
      @(negedge clock);
      c++;
    end
    check("reached_fourth_fall", fall_cnt, 4);
    repeat (6) @(negedge clock);
    dev_abort = 1'b1;
    reset     = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    check("midreset_ck_oe", ps2CkOe, 0);
    check("midreset_dq_oe", ps2DqOe, 0);
    check("midreset_busy", busy, 0);
    check("midreset_done", done, 0);
    check("midreset_error", error, 0);
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (done === 1'b1) seen++;
    end
    check("no_done_after_reset", seen, 0);
    c = 0;
    while (dev_active && c < 4 * HALF) begin
      @(negedge clock);
      c++;
    end
    dev_abort = 1'b0;
    repeat (5) @(negedge clock);
    xfer(8'hFF, M_ACK);

    // Randomized bytes and ack behaviour.
    for (int i = 0; i < 12; i++) begin
      xfer(8'($urandom), ($urandom_range(0, 3) == 0) ? M_NACK : M_ACK);
    end

    repeat (10) @(negedge clock);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
